// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } pipe_state_e;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Width of the control vector carried by ID/EX and EX/MEM; flush zeroes it.
  localparam int CTRL_W = 9;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic exmem_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = 7'b1101010;
  localparam pipe_ctrl_t CTRL_FREEZE = 7'b0000000;
  localparam pipe_ctrl_t CTRL_FLUSH  = 7'b1111111;
  localparam pipe_ctrl_t CTRL_STALL  = 7'b0001110;
  localparam pipe_ctrl_t CTRL_RESET  = 7'b0010101;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: instruction in EX loads a register read in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  idex_memread,
  output logic                  hazard
);

  assign hazard = idex_memread && (idex_rt != REG_ZERO) &&
                  ((idex_rt == id_rs) || (idex_rt == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/freeze sequencer for the 5-stage MIPS core.
// Optional PIPE_HAZ_PERF_EN adds stall_cycles/flush_events counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 64,
  parameter int CNT_W             = 8
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  exmem_branch_taken,
  input  logic                  exmem_mem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_flush,
  output logic                  exmem_write,
  output logic                  exmem_flush,
  output logic                  mem_err
`ifdef PIPE_HAZ_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIM     = CNT_W'(MEM_TIMEOUT);

  pipe_state_e      state_r, state_nxt_s, ret_state_r, ret_state_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r, stall_cnt_nxt_s, ret_cnt_r, ret_cnt_nxt_s;
  logic [CNT_W-1:0] to_cnt_r, to_cnt_nxt_s, to_inc_s;
  logic             mem_err_r, mem_err_nxt_s;
  logic             hazard_s, mem_wait_s, branch_s;
  pipe_ctrl_t       ctrl_s, ctrl_out_s;

  load_use_detect u_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .idex_rt      (idex_rt),
    .idex_memread (idex_memread),
    .hazard       (hazard_s)
  );

  assign mem_wait_s = exmem_mem_req && !dmem_ready;
  assign to_inc_s   = (to_cnt_r == {CNT_W{1'b1}}) ? to_cnt_r : to_cnt_r + 1'b1;

  // Next-state and control decode; priority memory wait > branch > load-use.
  always_comb begin
    ctrl_s          = CTRL_RUN;
    state_nxt_s     = state_r;
    stall_cnt_nxt_s = stall_cnt_r;
    ret_state_nxt_s = ret_state_r;
    ret_cnt_nxt_s   = ret_cnt_r;
    to_cnt_nxt_s    = to_cnt_r;
    mem_err_nxt_s   = mem_err_r;
    branch_s        = 1'b0;
    case (state_r)
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt_s     = ret_state_r;
          stall_cnt_nxt_s = ret_cnt_r;
          to_cnt_nxt_s    = {CNT_W{1'b0}};
        end else begin
          ctrl_s        = CTRL_FREEZE;
          to_cnt_nxt_s  = to_inc_s;
          mem_err_nxt_s = mem_err_r || (to_inc_s >= TO_LIM);
        end
      end
      RUN, LOAD_STALL: begin
        if (mem_wait_s) begin
          // The entry cycle already counts towards the timeout.
          ctrl_s          = CTRL_FREEZE;
          state_nxt_s     = MEM_WAIT;
          ret_state_nxt_s = state_r;
          ret_cnt_nxt_s   = stall_cnt_r;
          to_cnt_nxt_s    = to_inc_s;
          mem_err_nxt_s   = mem_err_r || (to_inc_s >= TO_LIM);
        end else if (exmem_branch_taken) begin
          ctrl_s          = CTRL_FLUSH;
          state_nxt_s     = RUN;
          stall_cnt_nxt_s = {CNT_W{1'b0}};
          branch_s        = 1'b1;
        end else if (state_r == LOAD_STALL) begin
          ctrl_s          = CTRL_STALL;
          stall_cnt_nxt_s = stall_cnt_r - 1'b1;
          state_nxt_s     = (stall_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) ? RUN : LOAD_STALL;
        end else if (hazard_s) begin
          ctrl_s          = CTRL_STALL;
          stall_cnt_nxt_s = STALL_LOAD;
          state_nxt_s     = (STALL_LOAD != {CNT_W{1'b0}}) ? LOAD_STALL : RUN;
        end else begin
          ctrl_s          = CTRL_RUN;
        end
      end
      default: begin
        state_nxt_s     = RUN;
        stall_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, saved-context, timeout and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      stall_cnt_r <= {CNT_W{1'b0}};
      ret_cnt_r   <= {CNT_W{1'b0}};
      to_cnt_r    <= {CNT_W{1'b0}};
      mem_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ret_state_r <= ret_state_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      ret_cnt_r   <= ret_cnt_nxt_s;
      to_cnt_r    <= to_cnt_nxt_s;
      mem_err_r   <= mem_err_nxt_s;
    end
  end

  assign ctrl_out_s  = rst ? CTRL_RESET : ctrl_s;
  assign pc_write    = ctrl_out_s.pc_write;
  assign ifid_write  = ctrl_out_s.ifid_write;
  assign ifid_flush  = ctrl_out_s.ifid_flush;
  assign idex_write  = ctrl_out_s.idex_write;
  assign idex_flush  = ctrl_out_s.idex_flush;
  assign exmem_write = ctrl_out_s.exmem_write;
  assign exmem_flush = ctrl_out_s.exmem_flush;
  assign mem_err     = mem_err_r && !rst;

`ifdef PIPE_HAZ_PERF_EN
  // Saturating stall-cycle and branch-flush event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!ctrl_s.pc_write && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (branch_s && (flush_events != 32'hFFFF_FFFF)) begin
        flush_events <= flush_events + 32'd1;
      end else begin
        flush_events <= flush_events;
      end
    end
  end
`endif

endmodule
